rs232out: RTL and testbench



---
 rtl/rs232out.sv | 188 ++++++++++++++++++
 tb/tb_rs232out.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs232out.sv
// rs232out: 8N1 asynchronous serial transmitter with a small valid/ready input FIFO.
// Bytes are shifted out LSB first, frames back-to-back while the FIFO has data.
// Optional build macro RS232OUT_PARITY_EN adds a parity bit after the data bits
// (even parity by default, odd when parameter odd_parity is set).
module rs232out #(
  parameter int bps       = 57_600,
  parameter int frequency = 25_000_000,
  parameter int period    = frequency / bps - 1,
  parameter int fifo_log2 = 2
`ifdef RS232OUT_PARITY_EN
  ,
  parameter bit odd_parity = 1'b0
`endif
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] transmit_data,
  input  logic       transmit_valid,
  output logic       transmit_ready,
  output logic       serial_out,
  output logic       idle
);

  localparam int DEPTH = 1 << fifo_log2;
  localparam int PW = fifo_log2 + 1;
  localparam logic [15:0] PERIOD16 = 16'(period);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef RS232OUT_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic          r_ready;

  state_t        r_state;
  logic [15:0]   r_baud;
  logic [2:0]    r_bitCount;
  logic [7:0]    r_shift;
  logic          r_serial;
  logic          r_idle;
`ifdef RS232OUT_PARITY_EN
  logic          r_parity;
`endif

  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_boundary;
  logic [PW-1:0] w_wrNext;
  logic [PW-1:0] w_rdNext;
  logic          w_fullNext;
  logic          w_emptyNext;
  logic [7:0]    w_head;

  assign w_empty     = (r_wrPtr == r_rdPtr);
  assign w_push      = transmit_valid & r_ready;
  assign w_boundary  = (r_baud == 16'd0);
  assign w_pop       = !w_empty && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_boundary));
  assign w_wrNext    = r_wrPtr + {{(PW-1){1'b0}}, w_push};
  assign w_rdNext    = r_rdPtr + {{(PW-1){1'b0}}, w_pop};
  assign w_fullNext  = (w_wrNext[PW-1] != w_rdNext[PW-1]) &&
                       (w_wrNext[PW-2:0] == w_rdNext[PW-2:0]);
  assign w_emptyNext = (w_wrNext == w_rdNext);
  assign w_head      = r_mem[r_rdPtr[fifo_log2-1:0]];

  assign transmit_ready = r_ready;
  assign serial_out     = r_serial;
  assign idle           = r_idle;

  // FIFO storage: written on every accepted byte, no reset needed since pointers gate reads.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wrPtr[fifo_log2-1:0]] <= transmit_data;
    end
  end

  // FIFO pointers and registered ready, computed from the post-update occupancy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_ready <= 1'b1;
    end else begin
      r_wrPtr <= w_wrNext;
      r_rdPtr <= w_rdNext;
      r_ready <= !w_fullNext;
    end
  end

  // Frame sequencer: baud timer, shift register, line driver and idle flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_baud     <= 16'd0;
      r_bitCount <= 3'd0;
      r_shift    <= 8'd0;
      r_serial   <= 1'b1;
      r_idle     <= 1'b1;
`ifdef RS232OUT_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      if (!w_boundary) begin
        r_baud <= r_baud - 16'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_shift  <= w_head;
`ifdef RS232OUT_PARITY_EN
            r_parity <= (^w_head) ^ odd_parity;
`endif
            r_serial <= 1'b0;
            r_baud   <= PERIOD16;
            r_state  <= S_START;
            r_idle   <= 1'b0;
          end else begin
            r_idle <= w_emptyNext;
          end
        end
        S_START: begin
          if (w_boundary) begin
            r_state    <= S_DATA;
            r_bitCount <= 3'd0;
            r_serial   <= r_shift[0];
            r_baud     <= PERIOD16;
          end
        end
        S_DATA: begin
          if (w_boundary) begin
            r_baud <= PERIOD16;
            if (r_bitCount == 3'd7) begin
`ifdef RS232OUT_PARITY_EN
              r_state  <= S_PARITY;
              r_serial <= r_parity;
`else
              r_state  <= S_STOP;
              r_serial <= 1'b1;
`endif
            end else begin
              r_shift    <= {1'b0, r_shift[7:1]};
              r_serial   <= r_shift[1];
              r_bitCount <= r_bitCount + 3'd1;
            end
          end
        end
`ifdef RS232OUT_PARITY_EN
        S_PARITY: begin
          if (w_boundary) begin
            r_state  <= S_STOP;
            r_serial <= 1'b1;
            r_baud   <= PERIOD16;
          end
        end
`endif
        S_STOP: begin
          if (w_boundary) begin
            if (w_pop) begin
              r_shift  <= w_head;
`ifdef RS232OUT_PARITY_EN
              r_parity <= (^w_head) ^ odd_parity;
`endif
              r_serial <= 1'b0;
              r_baud   <= PERIOD16;
              r_state  <= S_START;
            end else begin
              r_state <= S_IDLE;
              r_idle  <= w_emptyNext;
            end
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_serial <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rs232out.sv
// tb_rs232out: directed bench for rs232out at default parameters (434 clocks per bit).
// A line decoder process recovers frames from serial_out; the main sequence checks
// reset, abort, exact bit timing, loopback ordering, back-to-back frames and FIFO full.
module tb_rs232out;

  localparam int BIT = 434;
`ifdef RS232OUT_PARITY_EN
  localparam bit PAR = 1'b1;
  localparam int FRAME = 11 * BIT;
`else
  localparam bit PAR = 1'b0;
  localparam int FRAME = 10 * BIT;
`endif

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] transmit_data;
  logic       transmit_valid;
  logic       transmit_ready;
  logic       serial_out;
  logic       idle;

  int nAsserts = 0;
  int nFail = 0;
  int cyc = 0;
  bit monEn = 1'b0;

  logic [7:0] rxQ[$];
  int         fallQ[$];
  logic       stopQ[$];
  logic       parQ[$];

  rs232out dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .transmit_data  (transmit_data),
    .transmit_valid (transmit_valid),
    .transmit_ready (transmit_ready),
    .serial_out     (serial_out),
    .idle           (idle)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clock = ~clock;

  // Edge counter used to time pushes against frame boundaries.
  always @(posedge clock) cyc <= cyc + 1;

  // Line decoder: finds each start bit and samples every following bit at mid-bit.
  initial begin : lineDecoder
    logic [7:0] mb;
    int fallT;
    forever begin
      @(negedge clock);
      if (monEn && reset_n && serial_out === 1'b0) begin
        fallT = cyc;
        repeat (BIT / 2) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clock);
          mb[i] = serial_out;
        end
        if (PAR) begin
          repeat (BIT) @(negedge clock);
          parQ.push_back(serial_out);
        end
        repeat (BIT) @(negedge clock);
        stopQ.push_back(serial_out);
        rxQ.push_back(mb);
        fallQ.push_back(fallT);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nAsserts++;
    assert (observed === expected)
    else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Offers one byte for a single cycle, starting and ending on a falling edge.
  task automatic applyStimulus(input logic [7:0] b);
    transmit_data  = b;
    transmit_valid = 1'b1;
    @(negedge clock);
    transmit_valid = 1'b0;
  endtask

  task automatic waitFrames(input int n, input int budget);
    int t;
    t = 0;
    while (rxQ.size() < n && t < budget) begin
      @(negedge clock);
      t++;
    end
    checkOutput("frame_count", rxQ.size(), n);
  endtask

  task automatic waitIdle(input int budget);
    int t;
    t = 0;
    while (idle !== 1'b1 && t < budget) begin
      @(negedge clock);
      t++;
    end
    checkOutput("wait_idle", idle, 1);
  endtask

  task automatic clearQueues();
    rxQ.delete();
    fallQ.delete();
    stopQ.delete();
    parQ.delete();
  endtask

  initial begin : mainSeq
    logic [7:0] lbExp [4];
    logic [7:0] b2b [6];
    int lowCnt;
    int runLen;
    int elapsed;
    int tF;
    int t;
    logic lvl;

    lbExp = '{8'h00, 8'hFF, 8'hA5, 8'h3C};
    b2b   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    reset_n        = 1'b0;
    transmit_data  = 8'h00;
    transmit_valid = 1'b0;

    // Reset values while clock toggles
    repeat (3) @(negedge clock);
    checkOutput("rst_serial", serial_out, 1);
    checkOutput("rst_ready", transmit_ready, 1);
    checkOutput("rst_idle", idle, 1);
    reset_n = 1'b1;
    @(negedge clock);

    // Reset mid-frame aborts frame and flushes FIFO
    $display("[TB] reset abort mid-frame");
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    repeat (1000) @(negedge clock);
    checkOutput("abort_midframe", serial_out, 0);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("abort_serial", serial_out, 1);
    checkOutput("abort_ready", transmit_ready, 1);
    checkOutput("abort_idle", idle, 1);
    @(negedge clock);
    reset_n = 1'b1;
    lowCnt = 0;
    repeat (2000) begin
      @(negedge clock);
      if (serial_out !== 1'b1) lowCnt++;
    end
    checkOutput("abort_no_tx", lowCnt, 0);
    checkOutput("abort_idle_after", idle, 1);

    // Single byte 0x55: latency and exact bit widths
    $display("[TB] single byte 0x55");
    applyStimulus(8'h55);
    checkOutput("single_latency_hi", serial_out, 1);
    checkOutput("single_idle_drop", idle, 0);
    @(negedge clock);
    checkOutput("single_fall", serial_out, 0);
    elapsed = 0;
    for (int r = 0; r < 9; r++) begin
      lvl = r[0];
      runLen = 0;
      while (serial_out === lvl && runLen < 5000) begin
        runLen++;
        @(negedge clock);
      end
      checkOutput($sformatf("single_run%0d", r), runLen, (PAR && r == 8) ? 2 * BIT : BIT);
      elapsed += runLen;
    end
    repeat (FRAME - 1 - elapsed) @(negedge clock);
    checkOutput("single_stop", serial_out, 1);
    checkOutput("single_idle_late", idle, 0);
    @(negedge clock);
    checkOutput("single_idle_rise", idle, 1);

    // Loopback stream with a push coinciding with the stop-bit pop
    $display("[TB] loopback stream");
    clearQueues();
    monEn = 1'b1;
    applyStimulus(8'h00);
    @(negedge clock);
    tF = cyc;
    repeat (10) @(negedge clock);
    applyStimulus(8'hFF);
    t = 0;
    while (cyc < tF + FRAME - 1 && t < 2 * FRAME) begin
      @(negedge clock);
      t++;
    end
    applyStimulus(8'hA5);
    repeat (100) @(negedge clock);
    applyStimulus(8'h3C);
    waitFrames(4, 5 * FRAME);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("lb_byte%0d", i), rxQ[i], lbExp[i]);
      checkOutput($sformatf("lb_stop%0d", i), stopQ[i], 1);
      if (PAR) checkOutput($sformatf("lb_par%0d", i), parQ[i], ^lbExp[i]);
    end
    for (int i = 1; i < 4; i++) begin
      checkOutput($sformatf("lb_gap%0d", i), fallQ[i] - fallQ[i-1], FRAME);
    end
    waitIdle(2 * FRAME);

`ifdef RS232OUT_PARITY_EN
    // Parity bit values for odd and even popcounts
    $display("[TB] parity values");
    clearQueues();
    applyStimulus(8'h07);
    applyStimulus(8'h03);
    waitFrames(2, 4 * FRAME);
    checkOutput("par_07", parQ[0], 1);
    checkOutput("par_03", parQ[1], 0);
    waitIdle(2 * FRAME);
`endif

    // Back-to-back pushes, FIFO fills, valid held against a full FIFO
    $display("[TB] back-to-back and full FIFO");
    clearQueues();
    for (int i = 0; i < 5; i++) begin
      transmit_data  = b2b[i];
      transmit_valid = 1'b1;
      @(negedge clock);
      checkOutput($sformatf("b2b_ready%0d", i), transmit_ready, (i < 4) ? 1 : 0);
    end
    transmit_data = b2b[5];
    t = 0;
    while (transmit_ready !== 1'b1 && t < 2 * FRAME) begin
      @(negedge clock);
      t++;
    end
    checkOutput("b2b_hold_cycles", t, FRAME - 3);
    @(negedge clock);
    transmit_valid = 1'b0;
    checkOutput("b2b_refull", transmit_ready, 0);
    waitFrames(6, 8 * FRAME);
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("b2b_byte%0d", i), rxQ[i], b2b[i]);
    end
    for (int i = 1; i < 6; i++) begin
      checkOutput($sformatf("b2b_gap%0d", i), fallQ[i] - fallQ[i-1], FRAME);
    end
    waitIdle(2 * FRAME);
    checkOutput("end_ready", transmit_ready, 1);
    checkOutput("end_serial", serial_out, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
